pipe_reg_chain: RTL and testbench

Parametrised pipeline-stage register chain for the pipelined MIPS CPU. It replaces fixed, hard-wired inter-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB. It carries a WIDTH-bit control+data bundle through DEPTH register stages with per-stage valid bits, a valid/ready stall handshake, synchronous flush, and selectable bubble-collapsing. The hazard unit drives `flush` and `out_ready`. Datapath stages pack their fields into `in_data` and unpack them from `out_data`.

---
 rtl/pipe_reg_chain.sv | 95 +++++++++
 tb/tb_pipe_reg_chain.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline-stage register chain with per-stage valid bits,
// valid/ready stall handshake, synchronous flush and optional bubble collapsing.
module pipe_reg_chain #(
  parameter int unsigned WIDTH    = 71,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned COLLAPSE = 1,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] d_en;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             adv;
  logic             r_acc;

  // Per-stage load enables and next valid state.
  always_comb begin
    rdy     = '0;
    up_v    = '0;
    d_en    = '0;
    v_d     = v_q;
    count_d = '0;
    adv     = out_ready || !v_q[DEPTH-1];
    r_acc   = out_ready;

    for (int i = DEPTH - 1; i >= 0; i--) begin
      r_acc  = !v_q[i] || r_acc;
      rdy[i] = (COLLAPSE != 0) ? r_acc : adv;
    end

    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i] = up_v[i];
      end
      d_en[i] = !flush && rdy[i] && up_v[i];
    end

    // Flush wins over every transfer; payload registers are left untouched.
    if (flush) begin
      v_d = '0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (d_en[i]) begin
          d_q[i] <= up_d[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: default, collapsing, lockstep and single-stage chains.
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [7:0]  din;
  logic [70:0] in_data;

  logic        a_ir, a_ov;
  logic [70:0] a_dout;
  logic [1:0]  a_cnt;
  logic        b_ir, b_ov;
  logic [7:0]  b_dout;
  logic [1:0]  b_cnt;
  logic        c_ir, c_ov;
  logic [7:0]  c_dout;
  logic [1:0]  c_cnt;
  logic        e_ir, e_ov;
  logic [7:0]  e_dout;
  logic [0:0]  e_cnt;

  int errors = 0;
  int checks = 0;

  assign in_data = {63'd0, din};

  always #5 clk = ~clk;

  pipe_reg_chain u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .flush(flush), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_dout), .count(a_cnt)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .COLLAPSE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(din),
    .flush(flush), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_dout), .count(b_cnt)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .COLLAPSE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(din),
    .flush(flush), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_dout), .count(c_cnt)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .COLLAPSE(1)) u_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_ir), .in_data(din),
    .flush(flush), .out_valid(e_ov), .out_ready(out_ready), .out_data(e_dout), .count(e_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic       fl;
    logic       ordy;
    logic [7:0] din;
    logic       ci;
    logic       ir;
    logic       ov;
    logic       cd;
    logic [7:0] dout;
    logic [1:0] cnt;
  } vec_t;

  localparam int unsigned NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [7:0] dv,
                       input logic fl, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; din = dv; flush = fl; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din = 8'h00; flush = 1'b0; out_ready = 1'b0;

    //            rst iv fl ordy din    ci ir ov cd dout   cnt
    vecs[0]  = '{1, 1, 0, 1, 8'h5A, 0, 0, 0, 1, 8'h00, 0};
    vecs[1]  = '{1, 1, 0, 1, 8'h5A, 0, 0, 0, 1, 8'h00, 0};
    vecs[2]  = '{0, 1, 0, 1, 8'h01, 1, 1, 0, 0, 8'h00, 1};
    vecs[3]  = '{0, 1, 0, 1, 8'h02, 1, 1, 1, 1, 8'h01, 2};
    vecs[4]  = '{0, 1, 0, 1, 8'h03, 1, 1, 1, 1, 8'h02, 2};
    vecs[5]  = '{0, 1, 0, 1, 8'h04, 1, 1, 1, 1, 8'h03, 2};
    vecs[6]  = '{0, 0, 0, 1, 8'h00, 1, 1, 1, 1, 8'h04, 1};
    vecs[7]  = '{0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vecs[8]  = '{0, 1, 0, 0, 8'h10, 1, 1, 0, 0, 8'h00, 1};
    vecs[9]  = '{0, 1, 0, 0, 8'h11, 1, 1, 1, 1, 8'h10, 2};
    vecs[10] = '{0, 1, 0, 0, 8'h12, 1, 0, 1, 1, 8'h10, 2};
    vecs[11] = '{0, 1, 0, 1, 8'h12, 1, 1, 1, 1, 8'h11, 2};
    vecs[12] = '{0, 1, 0, 0, 8'h13, 1, 0, 1, 1, 8'h11, 2};
    vecs[13] = '{0, 1, 0, 1, 8'h13, 1, 1, 1, 1, 8'h12, 2};
    vecs[14] = '{0, 1, 1, 1, 8'h14, 1, 1, 0, 0, 8'h00, 0};
    vecs[15] = '{0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vecs[16] = '{0, 1, 0, 1, 8'h20, 1, 1, 0, 0, 8'h00, 1};
    vecs[17] = '{1, 1, 0, 1, 8'h21, 0, 1, 0, 1, 8'h00, 0};
    vecs[18] = '{0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0};

    // Default chain: reset, streaming, stall toggling, flush, mid-stream reset.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].fl, vecs[i].ordy);
      if (vecs[i].ci) chk($sformatf("a_in_ready[%0d]", i), 71'(a_ir), 71'(vecs[i].ir));
      tick();
      chk($sformatf("a_out_valid[%0d]", i), 71'(a_ov), 71'(vecs[i].ov));
      chk($sformatf("a_count[%0d]", i), 71'(a_cnt), 71'(vecs[i].cnt));
      if (vecs[i].cd) chk($sformatf("a_out_data[%0d]", i), a_dout, 71'(vecs[i].dout));
    end

    // Collapse versus lockstep: A, idle, B, C with downstream stalled.
    do_reset();
    drive(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0); tick();
    chk("b_cnt_e1", 71'(b_cnt), 71'(1));
    chk("c_cnt_e1", 71'(c_cnt), 71'(1));
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0); tick();
    chk("b_ov_e3", 71'(b_ov), 71'(1));
    chk("b_dout_e3", 71'(b_dout), 71'(8'hA1));
    chk("c_ov_e3", 71'(c_ov), 71'(1));
    chk("c_cnt_e3", 71'(c_cnt), 71'(2));
    drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    chk("b_ir_e4", 71'(b_ir), 71'(1));
    chk("c_ir_e4", 71'(c_ir), 71'(0));
    tick();
    chk("b_cnt_full", 71'(b_cnt), 71'(3));
    chk("b_ir_full", 71'(b_ir), 71'(0));
    chk("c_cnt_hold", 71'(c_cnt), 71'(2));
    chk("c_dout_hold", 71'(c_dout), 71'(8'hA1));
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("b_ir_drain", 71'(b_ir), 71'(1));
    chk("c_ir_drain", 71'(c_ir), 71'(1));
    tick();
    chk("b_dout_e5", 71'(b_dout), 71'(8'hB2));
    chk("b_cnt_e5", 71'(b_cnt), 71'(2));
    chk("c_ov_bubble", 71'(c_ov), 71'(0));
    chk("c_cnt_e5", 71'(c_cnt), 71'(1));
    tick();
    chk("b_ov_e6", 71'(b_ov), 71'(1));
    chk("b_dout_e6", 71'(b_dout), 71'(8'hC3));
    chk("c_ov_e6", 71'(c_ov), 71'(1));
    chk("c_dout_e6", 71'(c_dout), 71'(8'hB2));
    tick();
    chk("b_ov_e7", 71'(b_ov), 71'(0));
    chk("c_cnt_e7", 71'(c_cnt), 71'(0));

    // Flush a full 3-deep chain while 0xFF is offered.
    drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0); tick();
    chk("b_cnt_prefl", 71'(b_cnt), 71'(3));
    chk("b_dout_prefl", 71'(b_dout), 71'(8'h11));
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
    chk("b_ir_flush", 71'(b_ir), 71'(1));
    tick();
    chk("b_cnt_flush", 71'(b_cnt), 71'(0));
    chk("b_ov_flush", 71'(b_ov), 71'(0));
    chk("c_cnt_flush", 71'(c_cnt), 71'(0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); tick();
      chk($sformatf("b_ov_postfl[%0d]", k), 71'(b_ov), 71'(0));
    end

    // Single-stage chain.
    do_reset();
    drive(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    chk("e_ir_empty", 71'(e_ir), 71'(1));
    tick();
    chk("e_ov_1", 71'(e_ov), 71'(1));
    chk("e_dout_1", 71'(e_dout), 71'(8'h07));
    drive(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    chk("e_ir_stall", 71'(e_ir), 71'(0));
    tick();
    chk("e_dout_hold", 71'(e_dout), 71'(8'h07));
    drive(1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
    chk("e_ir_pass", 71'(e_ir), 71'(1));
    tick();
    chk("e_dout_2", 71'(e_dout), 71'(8'h08));
    chk("e_cnt_2", 71'(e_cnt), 71'(1));
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("e_ov_empty", 71'(e_ov), 71'(0));
    chk("e_cnt_empty", 71'(e_cnt), 71'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
